// File: rtl/arch_reg_reader.sv
// Debug responder: drains the core, then streams committed architectural
// register values (areg, preg, data) over a valid/ready response channel.
`timescale 1ns/1ps

module arch_reg_reader #(
    parameter int unsigned NUM_AREGS     = 32,
    parameter int unsigned PREG_W        = 7,
    parameter int unsigned DATA_W        = 32,
    parameter int unsigned DRAIN_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    // request channel
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_all,
    input  logic [$clog2(NUM_AREGS)-1:0] req_areg,
    // response channel
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_AREGS)-1:0] rsp_areg,
    output logic [PREG_W-1:0]            rsp_preg,
    output logic [DATA_W-1:0]            rsp_data,
    output logic                         rsp_last,
    output logic                         rsp_err,
    // core interface
    output logic                         hold_fetch,
    input  logic                         rob_empty,
    output logic [$clog2(NUM_AREGS)-1:0] map_raddr,
    input  logic [PREG_W-1:0]            map_rdata,
    output logic [PREG_W-1:0]            prf_raddr,
    input  logic [DATA_W-1:0]            prf_rdata
);

    localparam int unsigned AREG_W = $clog2(NUM_AREGS);
    localparam int unsigned CNT_W  = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

    localparam logic [AREG_W-1:0] LAST_AREG = AREG_W'(NUM_AREGS - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StDrain,
        StMap,
        StPrd,
        StCap,
        StResp
    } state_e;

    state_e              state_q;
    logic [AREG_W-1:0]   cur_areg_q;
    logic                all_q;
    logic [CNT_W-1:0]    drain_cnt_q;
    logic [PREG_W-1:0]   preg_q;

    // Request handshake and read-port addresses decode straight from the state.
    always_comb begin
        req_ready = (state_q == StIdle);
        map_raddr = (state_q == StMap) ? cur_areg_q : '0;
        prf_raddr = (state_q == StPrd) ? preg_q : '0;
    end

    // Main sequencer: drain, translate, read, respond; all rsp_* are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_areg_q  <= '0;
            all_q       <= 1'b0;
            drain_cnt_q <= '0;
            preg_q      <= '0;
            rsp_valid   <= 1'b0;
            rsp_areg    <= '0;
            rsp_preg    <= '0;
            rsp_data    <= '0;
            rsp_last    <= 1'b0;
            rsp_err     <= 1'b0;
            hold_fetch  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        cur_areg_q  <= req_all ? '0 : req_areg;
                        all_q       <= req_all;
                        drain_cnt_q <= '0;
                        hold_fetch  <= 1'b1;
                        state_q     <= StDrain;
                    end
                end
                StDrain: begin
                    if (rob_empty) begin
                        state_q <= StMap;
                    end else if (drain_cnt_q == CNT_LAST) begin
                        // Core never drained: single error beat ends the request.
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_last  <= 1'b1;
                        rsp_data  <= '0;
                        rsp_preg  <= '0;
                        rsp_areg  <= cur_areg_q;
                        state_q   <= StResp;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + CNT_W'(1);
                    end
                end
                StMap: begin
                    preg_q  <= map_rdata;
                    state_q <= StPrd;
                end
                StPrd: begin
                    state_q <= StCap;
                end
                StCap: begin
                    // x0 reads as zero regardless of what its mapping holds.
                    rsp_data  <= (cur_areg_q == '0) ? '0 : prf_rdata;
                    rsp_preg  <= preg_q;
                    rsp_areg  <= cur_areg_q;
                    rsp_last  <= !all_q || (cur_areg_q == LAST_AREG);
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state_q   <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        if (rsp_last) begin
                            rsp_err    <= 1'b0;
                            hold_fetch <= 1'b0;
                            state_q    <= StIdle;
                        end else begin
                            // Fetch is still held, so the next beat skips the drain.
                            cur_areg_q <= cur_areg_q + AREG_W'(1);
                            state_q    <= StMap;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arch_reg_reader.sv
// Directed bench for arch_reg_reader: a default-timeout instance for the
// functional scenarios and a short-timeout instance for the drain timeout.
`timescale 1ns/1ps

module tb_arch_reg_reader;

    localparam int unsigned PREG_W = 7;
    localparam int unsigned DATA_W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    // Main instance signals
    logic              req_valid, req_ready, req_all;
    logic [4:0]        req_areg;
    logic              rsp_valid, rsp_ready, rsp_last, rsp_err;
    logic [4:0]        rsp_areg;
    logic [PREG_W-1:0] rsp_preg;
    logic [DATA_W-1:0] rsp_data;
    logic              hold_fetch, rob_empty;
    logic [4:0]        map_raddr;
    logic [PREG_W-1:0] map_rdata, prf_raddr;
    logic [DATA_W-1:0] prf_rdata;

    // Short-timeout instance signals
    logic              t_req_valid, t_req_ready, t_req_all;
    logic [4:0]        t_req_areg;
    logic              t_rsp_valid, t_rsp_ready, t_rsp_last, t_rsp_err;
    logic [4:0]        t_rsp_areg;
    logic [PREG_W-1:0] t_rsp_preg;
    logic [DATA_W-1:0] t_rsp_data;
    logic              t_hold_fetch, t_rob_empty;
    logic [4:0]        t_map_raddr;
    logic [PREG_W-1:0] t_map_rdata, t_prf_raddr;
    logic [DATA_W-1:0] t_prf_rdata;

    // Rename map (combinational) and PRF (1-cycle read) models
    logic [PREG_W-1:0] map_mem [32];
    logic [DATA_W-1:0] prf_mem [128];

    assign map_rdata   = map_mem[map_raddr];
    assign t_map_rdata = map_mem[t_map_raddr];
    always_ff @(posedge clk) begin
        prf_rdata   <= prf_mem[prf_raddr];
        t_prf_rdata <= prf_mem[t_prf_raddr];
    end

    arch_reg_reader u_dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_all    (req_all),
        .req_areg   (req_areg),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_areg   (rsp_areg),
        .rsp_preg   (rsp_preg),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .rsp_err    (rsp_err),
        .hold_fetch (hold_fetch),
        .rob_empty  (rob_empty),
        .map_raddr  (map_raddr),
        .map_rdata  (map_rdata),
        .prf_raddr  (prf_raddr),
        .prf_rdata  (prf_rdata)
    );

    arch_reg_reader #(
        .DRAIN_TIMEOUT (16)
    ) u_dut_to (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (t_req_valid),
        .req_ready  (t_req_ready),
        .req_all    (t_req_all),
        .req_areg   (t_req_areg),
        .rsp_valid  (t_rsp_valid),
        .rsp_ready  (t_rsp_ready),
        .rsp_areg   (t_rsp_areg),
        .rsp_preg   (t_rsp_preg),
        .rsp_data   (t_rsp_data),
        .rsp_last   (t_rsp_last),
        .rsp_err    (t_rsp_err),
        .hold_fetch (t_hold_fetch),
        .rob_empty  (t_rob_empty),
        .map_raddr  (t_map_raddr),
        .map_rdata  (t_map_rdata),
        .prf_raddr  (t_prf_raddr),
        .prf_rdata  (t_prf_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic load_dump_tables();
        for (int i = 0; i < 32; i++) map_mem[i] = PREG_W'(i + 32);
        for (int p = 0; p < 128; p++) prf_mem[p] = DATA_W'(p * 3);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid = 1'b0; req_all = 1'b0; req_areg = '0; rsp_ready = 1'b0; rob_empty = 1'b0;
        t_req_valid = 1'b0; t_req_all = 1'b0; t_req_areg = '0; t_rsp_ready = 1'b0;
        t_rob_empty = 1'b0;
        load_dump_tables();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || hold_fetch !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b hold_fetch=%b, want 1 0 0",
                     req_ready, rsp_valid, hold_fetch);
        end
        checks++;
        if (rsp_data !== '0 || rsp_last !== 1'b0 || rsp_err !== 1'b0 || map_raddr !== '0
            || prf_raddr !== '0) begin
            errors++;
            $display("FAIL reset_fields: data=%h last=%b err=%b maddr=%0d paddr=%0d, want zeros",
                     rsp_data, rsp_last, rsp_err, map_raddr, prf_raddr);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || t_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b/%b want 1/1", req_ready, t_req_ready);
        end
    endtask

    task automatic test_single();
        map_mem[10] = 7'd42;
        prf_mem[42] = 32'h0000_1234;
        rob_empty = 1'b1; rsp_ready = 1'b0; req_all = 1'b0; req_areg = 5'd10; req_valid = 1'b1;
        @(posedge clk);  // accept edge N
        #1;
        req_valid = 1'b0;
        checks++;
        if (hold_fetch !== 1'b1 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: hold_fetch=%b req_ready=%b want 1 0",
                     hold_fetch, req_ready);
        end
        @(posedge clk);  // N+1: MAP
        #1;
        checks++;
        if (map_raddr !== 5'd10) begin
            errors++;
            $display("FAIL single_map_raddr: got %0d want 10", map_raddr);
        end
        @(posedge clk);  // N+2: PRD
        #1;
        checks++;
        if (prf_raddr !== 7'd42 || map_raddr !== 5'd0) begin
            errors++;
            $display("FAIL single_prf_raddr: prf=%0d map=%0d want 42 0", prf_raddr, map_raddr);
        end
        @(posedge clk);  // N+3: CAP
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_early_valid: got %b want 0", rsp_valid);
        end
        @(posedge clk);  // N+4: RESP
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_areg !== 5'd10 || rsp_preg !== 7'd42
            || rsp_data !== 32'h0000_1234 || rsp_last !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL single_beat: v=%b areg=%0d preg=%0d data=%h last=%b err=%b, want 1 10 42 00001234 1 0",
                     rsp_valid, rsp_areg, rsp_preg, rsp_data, rsp_last, rsp_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || hold_fetch !== 1'b0) begin
            errors++;
            $display("FAIL single_done: v=%b req_ready=%b hold=%b want 0 1 0",
                     rsp_valid, req_ready, hold_fetch);
        end
    endtask

    task automatic test_full_dump();
        int n;
        logic [DATA_W-1:0] exp_data;
        load_dump_tables();
        rob_empty = 1'b1; rsp_ready = 1'b1; req_all = 1'b1; req_areg = 5'd7; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_all = 1'b0;
        for (int i = 0; i < 32; i++) begin
            n = 0;
            while (rsp_valid !== 1'b1 && n < 10) begin
                @(posedge clk);
                #1;
                n++;
                checks++;
                if (hold_fetch !== 1'b1) begin
                    errors++;
                    $display("FAIL dump_hold_fetch beat %0d: got %b want 1", i, hold_fetch);
                end
            end
            checks++;
            if (rsp_valid !== 1'b1) begin
                errors++;
                $display("FAIL dump_timeout beat %0d: rsp_valid=%b want 1", i, rsp_valid);
                break;
            end
            // First beat: accept + DRAIN/MAP/PRD/CAP; later beats: MAP/PRD/CAP after handshake
            checks++;
            if (n != ((i == 0) ? 4 : 3)) begin
                errors++;
                $display("FAIL dump_latency beat %0d: got %0d want %0d", i, n, (i == 0) ? 4 : 3);
            end
            exp_data = (i == 0) ? '0 : DATA_W'((i + 32) * 3);
            checks++;
            if (rsp_areg !== 5'(i) || rsp_preg !== PREG_W'(i + 32) || rsp_data !== exp_data
                || rsp_last !== (i == 31) || rsp_err !== 1'b0) begin
                errors++;
                $display("FAIL dump_beat %0d: areg=%0d preg=%0d data=%h last=%b err=%b, want %0d %0d %h %b 0",
                         i, rsp_areg, rsp_preg, rsp_data, rsp_last, rsp_err,
                         i, i + 32, exp_data, (i == 31));
            end
            @(posedge clk);  // handshake
            #1;
        end
        rsp_ready = 1'b0;
        checks++;
        if (hold_fetch !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_end: hold=%b req_ready=%b v=%b want 0 1 0",
                     hold_fetch, req_ready, rsp_valid);
        end
    endtask

    task automatic test_backpressure();
        int n;
        load_dump_tables();
        rob_empty = 1'b1; rsp_ready = 1'b1; req_all = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_all = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);  // beat 0 handshake
        #1;
        rsp_ready = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_beat1_timeout: rsp_valid=%b want 1", rsp_valid);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_areg !== 5'd1 || rsp_preg !== 7'd33
                || rsp_data !== 32'd99 || rsp_last !== 1'b0 || hold_fetch !== 1'b1
                || map_raddr !== 5'd0) begin
                errors++;
                $display("FAIL bp_hold cycle %0d: v=%b areg=%0d preg=%0d data=%h last=%b hold=%b maddr=%0d, want 1 1 33 00000063 0 1 0",
                         c, rsp_valid, rsp_areg, rsp_preg, rsp_data, rsp_last, hold_fetch,
                         map_raddr);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || map_raddr !== 5'd2) begin
            errors++;
            $display("FAIL bp_release: v=%b maddr=%0d want 0 2", rsp_valid, map_raddr);
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || hold_fetch !== 1'b0) begin
            errors++;
            $display("FAIL bp_finish: req_ready=%b hold=%b want 1 0", req_ready, hold_fetch);
        end
    endtask

    task automatic test_drain_wait();
        map_mem[5] = 7'd37;
        prf_mem[37] = 32'hCAFE_0005;
        rob_empty = 1'b0; rsp_ready = 1'b0; req_all = 1'b0; req_areg = 5'd5; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (hold_fetch !== 1'b1) begin
            errors++;
            $display("FAIL drain_hold_fetch: got %b want 1", hold_fetch);
        end
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            checks++;
            if (hold_fetch !== 1'b1 || map_raddr !== 5'd0 || rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL drain_wait cycle %0d: hold=%b maddr=%0d v=%b want 1 0 0",
                         c, hold_fetch, map_raddr, rsp_valid);
            end
        end
        rob_empty = 1'b1;
        @(posedge clk);
        #1;
        rob_empty = 1'b0;  // later toggling must not matter
        checks++;
        if (map_raddr !== 5'd5) begin
            errors++;
            $display("FAIL drain_enter_map: maddr=%0d want 5", map_raddr);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_areg !== 5'd5 || rsp_preg !== 7'd37
            || rsp_data !== 32'hCAFE_0005 || rsp_last !== 1'b1 || rsp_err !== 1'b0) begin
            errors++;
            $display("FAIL drain_beat: v=%b areg=%0d preg=%0d data=%h last=%b err=%b, want 1 5 37 cafe0005 1 0",
                     rsp_valid, rsp_areg, rsp_preg, rsp_data, rsp_last, rsp_err);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || hold_fetch !== 1'b0) begin
            errors++;
            $display("FAIL drain_done: req_ready=%b hold=%b want 1 0", req_ready, hold_fetch);
        end
    endtask

    task automatic test_timeout();
        int n;
        t_rob_empty = 1'b0; t_rsp_ready = 1'b0; t_req_all = 1'b0; t_req_areg = 5'd3;
        t_req_valid = 1'b1;
        @(posedge clk);
        #1;
        t_req_valid = 1'b0;
        n = 0;
        while (t_rsp_valid !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (t_rsp_valid !== 1'b1 || n != 16) begin
            errors++;
            $display("FAIL timeout_latency: v=%b cycles=%0d want 1 16", t_rsp_valid, n);
        end
        checks++;
        if (t_rsp_err !== 1'b1 || t_rsp_last !== 1'b1 || t_rsp_data !== '0 || t_rsp_preg !== '0
            || t_rsp_areg !== 5'd3 || t_hold_fetch !== 1'b1) begin
            errors++;
            $display("FAIL timeout_beat: err=%b last=%b data=%h preg=%0d areg=%0d hold=%b, want 1 1 0 0 3 1",
                     t_rsp_err, t_rsp_last, t_rsp_data, t_rsp_preg, t_rsp_areg, t_hold_fetch);
        end
        t_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        t_rsp_ready = 1'b0;
        checks++;
        if (t_req_ready !== 1'b1 || t_hold_fetch !== 1'b0 || t_rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: req_ready=%b hold=%b v=%b want 1 0 0",
                     t_req_ready, t_hold_fetch, t_rsp_valid);
        end
    endtask

    task automatic test_reset_mid_dump();
        int n;
        load_dump_tables();
        rob_empty = 1'b1; rsp_ready = 1'b1; req_all = 1'b1; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_all = 1'b0;
        n = 0;
        while (!(rsp_valid === 1'b1 && rsp_areg === 5'd5) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_areg !== 5'd5) begin
            errors++;
            $display("FAIL rmd_reach_beat5: v=%b areg=%0d want 1 5", rsp_valid, rsp_areg);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || hold_fetch !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmd_async: v=%b hold=%b req_ready=%b want 0 0 1",
                     rsp_valid, hold_fetch, req_ready);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        reset = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || hold_fetch !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rmd_next_cycle: v=%b hold=%b req_ready=%b want 0 0 1",
                     rsp_valid, hold_fetch, req_ready);
        end
        @(posedge clk);
        #1;
        test_single();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_dump();
        test_backpressure();
        test_drain_wait();
        test_timeout();
        test_reset_mid_dump();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
